alu_ain_fwd_stage: RTL and testbench

//  Registered operand-A stage for the ALU, successor to the combinational A-input mux.

---
 rtl/alu_ain_fwd_stage_pkg.sv | 34 +++
 rtl/alu_ain_fwd_stage_if.sv | 35 +++
 rtl/alu_ain_skid_buf.sv | 104 ++++++++++
 rtl/alu_ain_fwd_stage.sv | 88 ++++++++
 tb/tb_alu_ain_fwd_stage.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_ain_fwd_stage_pkg.sv
`default_nettype none
// ==== alu_ain_fwd_stage_pkg | operand-A source codes and skid state encoding | rev 1.0 ====
`ifndef ALU_AInSrc_ZERO
`define ALU_AInSrc_ZERO 3'd0
`endif
`ifndef ALU_AInSrc_RF
`define ALU_AInSrc_RF 3'd1
`endif
`ifndef ALU_AInSrc_FWD0
`define ALU_AInSrc_FWD0 3'd2
`endif

package alu_ain_fwd_stage_pkg;

  localparam logic [2:0] SRC_ZERO = `ALU_AInSrc_ZERO;
  localparam logic [2:0] SRC_RF   = `ALU_AInSrc_RF;
  localparam logic [2:0] SRC_FWD0 = `ALU_AInSrc_FWD0;

  // out_src is 3 bits wide, so 2+k must stay below 8
  localparam int MAX_FWD = 6;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_t;

  function automatic logic [2:0] fwd_src(input int unsigned k);
    return SRC_FWD0 + 3'(k);
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_ain_fwd_stage_if.sv
`default_nettype none
// ==== alu_ain_fwd_stage_if | issue-slot, forwarding and EX handshake bundle | rev 1.0 ====
interface alu_ain_fwd_stage_if #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int NFWD   = 3
);

  logic                   in_valid;
  logic                   in_ready;
  logic                   zero_op;
  logic [REG_AW-1:0]      ra;
  logic [0:WIDTH-1]       rf_data;
  logic [NFWD-1:0]        fwd_valid;
  logic [NFWD-1:0]        fwd_pending;
  logic [NFWD*REG_AW-1:0] fwd_rd;
  logic [0:NFWD*WIDTH-1]  fwd_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [0:WIDTH-1]       out_data;
  logic [2:0]             out_src;

  modport master (
    output in_valid, zero_op, ra, rf_data, fwd_valid, fwd_pending, fwd_rd, fwd_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, zero_op, ra, rf_data, fwd_valid, fwd_pending, fwd_rd, fwd_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

endinterface

`default_nettype wire

// File: rtl/alu_ain_skid_buf.sv
`default_nettype none
// ==== alu_ain_skid_buf | operand output register; 2-entry FIFO skid when ALU_AIN_SKID_EN | rev 1.0 ====
module alu_ain_skid_buf
  import alu_ain_fwd_stage_pkg::*;
#(
  parameter int W = 35
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         s_valid,
  output logic              s_ready,
  input  wire logic [0:W-1] s_data,
  output logic              m_valid,
  input  wire logic         m_ready,
  output logic [0:W-1]      m_data
);

`ifdef ALU_AIN_SKID_EN

  skid_state_t  state;
  skid_state_t  state_nxt;
  logic [0:W-1] head;
  logic [0:W-1] tail;
  logic [0:W-1] head_nxt;
  logic [0:W-1] tail_nxt;
  logic         push;
  logic         pop;

  // s_ready depends on state only, so out_ready never reaches in_ready combinationally
  assign s_ready = (state != SKID_TWO);
  assign m_valid = (state != SKID_EMPTY);
  assign m_data  = head;

  always_comb begin
    push      = s_valid && s_ready;
    pop       = m_valid && m_ready;
    state_nxt = state;
    head_nxt  = head;
    tail_nxt  = tail;
    case (state)
      SKID_EMPTY: begin
        if (push) begin
          head_nxt  = s_data;
          state_nxt = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (push && pop) begin
          head_nxt = s_data;
        end else if (push) begin
          tail_nxt  = s_data;
          state_nxt = SKID_TWO;
        end else if (pop) begin
          state_nxt = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (pop) begin
          head_nxt  = tail;
          state_nxt = SKID_ONE;
        end
      end
      default: state_nxt = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SKID_EMPTY;
      head  <= '0;
      tail  <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      tail  <= tail_nxt;
    end
  end

`else

  logic         valid;
  logic [0:W-1] data;

  assign s_ready = ~valid | m_ready;
  assign m_valid = valid;
  assign m_data  = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (s_valid && s_ready) begin
      valid <= 1'b1;
      data  <= s_data;
    end else if (m_ready) begin
      valid <= 1'b0;
    end
  end

`endif

endmodule

`default_nettype wire

// File: rtl/alu_ain_fwd_stage.sv
`default_nettype none
// ==== alu_ain_fwd_stage | registered ALU A-operand select with RAW stall | rev 1.0 ====
// Build option ALU_AIN_SKID_EN: 2-entry skid output buffer, in_ready from flops.
module alu_ain_fwd_stage
  import alu_ain_fwd_stage_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5,
  parameter int NFWD   = 3,
  parameter int HZ_CW  = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  alu_ain_fwd_stage_if.slave bus,
  output logic [HZ_CW-1:0]   hz_cnt
);

  if (NFWD < 1 || NFWD > MAX_FWD || WIDTH < 1 || HZ_CW < 1) begin : g_param_check
    $error("alu_ain_fwd_stage: need 1 <= NFWD <= 6, WIDTH >= 1, HZ_CW >= 1");
  end

  logic             is_zero;
  logic             hit;
  logic             hit_pend;
  logic             hazard;
  logic             space;
  logic             s_valid;
  logic [2:0]       sel_src;
  logic [0:WIDTH-1] sel_data;
  logic [0:WIDTH+2] s_pay;
  logic [0:WIDTH+2] m_pay;

  assign is_zero = bus.zero_op && (bus.ra == '0);

  // Scan from the oldest channel down so the youngest match is the last one written.
  always_comb begin
    hit      = 1'b0;
    hit_pend = 1'b0;
    sel_src  = SRC_RF;
    sel_data = bus.rf_data;
    for (int k = NFWD - 1; k >= 0; k--) begin
      if (bus.fwd_valid[k] && (bus.fwd_rd[k*REG_AW +: REG_AW] == bus.ra)) begin
        hit      = 1'b1;
        hit_pend = bus.fwd_pending[k];
        sel_src  = fwd_src(k);
        sel_data = bus.fwd_data[k*WIDTH +: WIDTH];
      end
    end
    if (is_zero) begin
      hit      = 1'b0;
      hit_pend = 1'b0;
      sel_src  = SRC_ZERO;
      sel_data = '0;
    end
  end

  assign hazard       = bus.in_valid && hit && hit_pend;
  assign s_valid      = bus.in_valid && !hazard && !rst;
  assign bus.in_ready = !rst && !hazard && space;
  assign s_pay        = {sel_src, sel_data};

  alu_ain_skid_buf #(
    .W (WIDTH + 3)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (space),
    .s_data  (s_pay),
    .m_valid (bus.out_valid),
    .m_ready (bus.out_ready),
    .m_data  (m_pay)
  );

  assign bus.out_src  = m_pay[0:2];
  assign bus.out_data = m_pay[3:WIDTH+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      hz_cnt <= '0;
    end else if (hazard && !(&hz_cnt)) begin
      hz_cnt <= hz_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_ain_fwd_stage.sv
`default_nettype none
// ==== tb_alu_ain_fwd_stage | directed + randomized checks against a queue model of the stage | rev 1.0 ====
module tb_alu_ain_fwd_stage;

  localparam int WIDTH  = 32;
  localparam int REG_AW = 5;
  localparam int NFWD   = 3;
`ifdef ALU_AIN_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_ain_fwd_stage_if #(.WIDTH(WIDTH), .REG_AW(REG_AW), .NFWD(NFWD)) bus ();
  alu_ain_fwd_stage_if #(.WIDTH(WIDTH), .REG_AW(REG_AW), .NFWD(NFWD)) bus4 ();

  logic [15:0] hz;
  logic [3:0]  hz4;

  alu_ain_fwd_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW), .NFWD(NFWD), .HZ_CW(16)) dut (
    .clk(clk), .rst(rst), .bus(bus), .hz_cnt(hz)
  );
  alu_ain_fwd_stage #(.WIDTH(WIDTH), .REG_AW(REG_AW), .NFWD(NFWD), .HZ_CW(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4), .hz_cnt(hz4)
  );

  assign bus4.in_valid    = bus.in_valid;
  assign bus4.zero_op     = bus.zero_op;
  assign bus4.ra          = bus.ra;
  assign bus4.rf_data     = bus.rf_data;
  assign bus4.fwd_valid   = bus.fwd_valid;
  assign bus4.fwd_pending = bus.fwd_pending;
  assign bus4.fwd_rd      = bus.fwd_rd;
  assign bus4.fwd_data    = bus.fwd_data;
  assign bus4.out_ready   = bus.out_ready;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  typedef struct packed {
    logic [2:0]       src;
    logic [WIDTH-1:0] data;
    logic             pend;
  } sel_t;

  // Operand choice straight from the selection rules: zero form, else youngest matching channel, else RF.
  function automatic sel_t model_sel();
    sel_t r;
    r.src  = 3'd1;
    r.data = bus.rf_data;
    r.pend = 1'b0;
    if (bus.zero_op && bus.ra == 0) begin
      r.src  = 3'd0;
      r.data = '0;
      return r;
    end
    for (int k = 0; k < NFWD; k++) begin
      if (bus.fwd_valid[k] && bus.fwd_rd[k*REG_AW +: REG_AW] == bus.ra) begin
        r.src  = 3'(2 + k);
        r.data = bus.fwd_data[k*WIDTH +: WIDTH];
        r.pend = bus.fwd_pending[k];
        return r;
      end
    end
    return r;
  endfunction

  logic [34:0]  q[$];
  logic [31:0]  deliv[$];
  int unsigned  hzm  = 0;
  bit           done = 1'b0;
  bit           rec  = 1'b0;
  sel_t         ms;
  bit           mhaz;
  bit           mrdy;

  // Inputs only change just after posedge, so values at negedge are those the next edge samples.
  always @(negedge clk) begin
    if (!done) begin
      ms   = model_sel();
      mhaz = bus.in_valid && ms.pend;
      mrdy = !rst && !mhaz && (SKID ? (q.size() < 2) : (q.size() == 0 || bus.out_ready));
      chk("in_ready", bus.in_ready, mrdy);
      chk("in_ready_hz4", bus4.in_ready, mrdy);
      chk("out_valid", bus.out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("out_data", bus.out_data, q[0][31:0]);
        chk("out_src", bus.out_src, q[0][34:32]);
      end
      chk("hz_cnt", hz, (hzm > 65535) ? 65535 : hzm);
      chk("hz_cnt_sat4", hz4, (hzm > 15) ? 15 : hzm);
      if (rec && bus.out_valid && bus.out_ready) deliv.push_back(bus.out_data);
      if (rst) begin
        q.delete();
        hzm = 0;
      end else begin
        if (q.size() != 0 && bus.out_ready) void'(q.pop_front());
        if (bus.in_valid && mrdy) q.push_back({ms.src, ms.data});
        if (mhaz) hzm++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid    = 1'b0;
    bus.zero_op     = 1'b0;
    bus.ra          = '0;
    bus.rf_data     = '0;
    bus.fwd_valid   = '0;
    bus.fwd_pending = '0;
    bus.fwd_rd      = '0;
    bus.fwd_data    = '0;
    bus.out_ready   = 1'b1;
  endtask

  task automatic set_fwd(input int k, input bit v, input bit p, input logic [4:0] rd, input logic [31:0] d);
    bus.fwd_valid[k]                = v;
    bus.fwd_pending[k]              = p;
    bus.fwd_rd[k*REG_AW +: REG_AW]  = rd;
    bus.fwd_data[k*WIDTH +: WIDTH]  = d;
  endtask

  task automatic fire_and_check(input string nm, input logic [31:0] ed, input logic [2:0] es);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_valid"}, bus.out_valid, 1'b1);
    chk({nm, "_data"}, bus.out_data, ed);
    chk({nm, "_src"}, bus.out_src, es);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int  sent;
    bit  acc;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_hz", hz, 16'd0);

    // zero form overrides a matching forward
    step(); idle();
    bus.zero_op = 1'b1; bus.ra = 5'd0; bus.rf_data = 32'hDEAD_BEEF;
    set_fwd(0, 1'b1, 1'b0, 5'd0, 32'd5);
    fire_and_check("t_zero", 32'h0, 3'd0);

    // r0 without zero form is an ordinary register
    step(); idle();
    bus.ra = 5'd0; bus.rf_data = 32'h1234;
    fire_and_check("t_r0_rf", 32'h1234, 3'd1);

    // younger channel wins
    step(); idle();
    bus.ra = 5'd7; bus.rf_data = 32'h9;
    set_fwd(1, 1'b1, 1'b0, 5'd7, 32'hAA);
    set_fwd(2, 1'b1, 1'b0, 5'd7, 32'hBB);
    fire_and_check("t_prio", 32'hAA, 3'd3);

    // pending producer stalls for 3 cycles
    step(); idle(); rst = 1'b1;
    step(); rst = 1'b0;
    bus.ra = 5'd7; bus.rf_data = 32'h1;
    set_fwd(0, 1'b1, 1'b1, 5'd7, 32'h77);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk("t_stall_ready", bus.in_ready, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("t_stall_hz", hz, 16'd3);
    chk("t_stall_ready3", bus.in_ready, 1'b0);
    bus.fwd_pending[0] = 1'b0;
    fire_and_check("t_stall_fwd", 32'h77, 3'd2);

    // back-to-back with EX back-pressure in cycles 2-3
    step(); idle();
    deliv.delete();
    rec  = 1'b1;
    sent = 0;
    for (int cyc = 0; cyc < 40 && sent < 4; cyc++) begin
      bus.in_valid  = 1'b1;
      bus.ra        = 5'(sent + 1);
      bus.rf_data   = 32'h100 + 32'(sent);
      bus.out_ready = !(cyc == 2 || cyc == 3);
      @(negedge clk);
      acc = bus.in_ready;
      step();
      if (acc) sent++;
    end
    idle();
    repeat (4) step();
    rec = 1'b0;
    chk("t_b2b_sent", 32'(sent), 32'd4);
    chk("t_b2b_count", 32'(deliv.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < deliv.size()) chk("t_b2b_order", deliv[i], 32'h100 + 32'(i));
    end

    // reset while an operand is held
    idle();
    bus.out_ready = 1'b0; bus.ra = 5'd3; bus.rf_data = 32'h55;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t_rst_held", bus.out_valid, 1'b1);
    step();
    rst = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("t_rst_in_ready", bus.in_ready, 1'b0);
    step();
    rst = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("t_rst_out_valid", bus.out_valid, 1'b0);
    chk("t_rst_hz", hz, 16'd0);

    // saturation of a 4-bit stall counter
    step(); idle();
    bus.ra = 5'd9;
    set_fwd(0, 1'b1, 1'b1, 5'd9, 32'h3);
    bus.in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("t_sat_hz4", hz4, 4'd15);
    chk("t_sat_hz16", hz, 16'd20);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rst             = ($urandom_range(0, 199) == 0);
      bus.in_valid    = ($urandom_range(0, 3) != 0);
      bus.zero_op     = ($urandom_range(0, 3) == 0);
      bus.ra          = 5'($urandom_range(0, 3));
      bus.rf_data     = $urandom;
      bus.out_ready   = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NFWD; k++) begin
        set_fwd(k, 1'($urandom), ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 3)), $urandom);
      end
    end
    step();
    rst = 1'b0;
    idle();
    repeat (3) step();
    done = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
